// File: rtl/nibble_mem_arbiter.sv
// Two-requester arbiter owning the address/write port of a 64x4 nibble scratch memory.
// Define MEM_CLEAR_EN to build the post-reset sequencer that zeroes every nibble before serving.
module nibble_mem_arbiter #(
  parameter int unsigned AW         = 6,
  parameter int unsigned DW         = 4,
  parameter bit          PRIO_FIXED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rsp_valid,
  output logic [DW-1:0] a_rsp_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rsp_valid,
  output logic [DW-1:0] b_rsp_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          clear_done
);

  logic          clear_done_q;
  logic          pref_b_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          a_rsp_valid_q, b_rsp_valid_q;
  logic [DW-1:0] a_rsp_data_q, b_rsp_data_q;
  logic          a_win, b_win, a_gnt, b_gnt;

`ifdef MEM_CLEAR_EN
  typedef enum logic [0:0] {StClear, StServe} state_e;
  state_e        state_q;
  logic [AW-1:0] clr_cnt_q;
  logic          clearing;

  // Gated by rst so the clear strobe cannot appear while reset is still held.
  assign clearing = (state_q == StClear) && !rst;
`endif

  // On conflict A wins in fixed mode, otherwise whichever side the pointer favours.
  assign a_win = a_valid && (!b_valid || PRIO_FIXED || !pref_b_q);
  assign b_win = b_valid && !a_win;
  assign a_gnt = clear_done_q && a_win;
  assign b_gnt = clear_done_q && b_win;

  assign a_ready     = a_gnt;
  assign b_ready     = b_gnt;
  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign a_rsp_data  = a_rsp_data_q;
  assign b_rsp_data  = b_rsp_data_q;
  assign clear_done  = clear_done_q;

  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    if (a_gnt) begin
      mem_addr  = a_addr;
      mem_we    = a_we;
      mem_wdata = a_wdata;
    end else if (b_gnt) begin
      mem_addr  = b_addr;
      mem_we    = b_we;
      mem_wdata = b_wdata;
    end
`ifdef MEM_CLEAR_EN
    else if (clearing) begin
      mem_addr  = clr_cnt_q;
      mem_we    = 1'b1;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_done_q  <= 1'b0;
      pref_b_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_data_q  <= '0;
      b_rsp_data_q  <= '0;
`ifdef MEM_CLEAR_EN
      state_q       <= StClear;
      clr_cnt_q     <= '0;
`endif
    end else begin
      a_rsp_valid_q <= a_gnt;
      b_rsp_valid_q <= b_gnt;
      if (a_gnt) a_rsp_data_q <= mem_rdata;
      if (b_gnt) b_rsp_data_q <= mem_rdata;
      // Pointer moves only on a grant, so a lone requester keeps winning.
      if (a_gnt) begin
        pref_b_q <= 1'b1;
      end else if (b_gnt) begin
        pref_b_q <= 1'b0;
      end
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
`ifdef MEM_CLEAR_EN
      unique case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + AW'(1);
          if (clr_cnt_q == '1) begin
            state_q      <= StServe;
            clear_done_q <= 1'b1;
          end
        end
        StServe: clear_done_q <= 1'b1;
      endcase
`else
      clear_done_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_mem_arbiter.sv
// Bench for nibble_mem_arbiter: round-robin and fixed-priority instances share stimulus,
// each backed by its own memory and checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_nibble_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 4;
  localparam int DEPTH = 64;
`ifdef MEM_CLEAR_EN
  localparam int CLR_CYC = 64;
`else
  localparam int CLR_CYC = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_valid, a_we, b_valid, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ready_w [2];
  logic          b_ready_w [2];
  logic          a_rsp_valid_w [2];
  logic          b_rsp_valid_w [2];
  logic [DW-1:0] a_rsp_data_w [2];
  logic [DW-1:0] b_rsp_data_w [2];
  logic [AW-1:0] mem_addr_w [2];
  logic          mem_we_w [2];
  logic [DW-1:0] mem_wdata_w [2];
  logic [DW-1:0] mem_rdata_w [2];
  logic          clear_done_w [2];

  nibble_mem_arbiter #(.AW(AW), .DW(DW), .PRIO_FIXED(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready_w[0]), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid_w[0]), .a_rsp_data(a_rsp_data_w[0]),
    .b_valid(b_valid), .b_ready(b_ready_w[0]), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid_w[0]), .b_rsp_data(b_rsp_data_w[0]),
    .mem_addr(mem_addr_w[0]), .mem_we(mem_we_w[0]), .mem_wdata(mem_wdata_w[0]),
    .mem_rdata(mem_rdata_w[0]), .clear_done(clear_done_w[0])
  );

  nibble_mem_arbiter #(.AW(AW), .DW(DW), .PRIO_FIXED(1'b1)) u_fx (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready_w[1]), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid_w[1]), .a_rsp_data(a_rsp_data_w[1]),
    .b_valid(b_valid), .b_ready(b_ready_w[1]), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid_w[1]), .b_rsp_data(b_rsp_data_w[1]),
    .mem_addr(mem_addr_w[1]), .mem_we(mem_we_w[1]), .mem_wdata(mem_wdata_w[1]),
    .mem_rdata(mem_rdata_w[1]), .clear_done(clear_done_w[1])
  );

  // Memory macros with a preload port used while reset is held.
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  assign mem_rdata_w[0] = mem0[mem_addr_w[0]];
  assign mem_rdata_w[1] = mem1[mem_addr_w[1]];
  always @(posedge clk) begin
    if (load_en) mem0[load_addr] <= load_data;
    else if (mem_we_w[0]) mem0[mem_addr_w[0]] <= mem_wdata_w[0];
  end
  always @(posedge clk) begin
    if (load_en) mem1[load_addr] <= load_data;
    else if (mem_we_w[1]) mem1[mem_addr_w[1]] <= mem_wdata_w[1];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [2][DEPTH];
  bit            pref_b [2];
  logic [AW-1:0] last_addr [2];
  logic          exp_arv [2];
  logic          exp_brv [2];
  logic [DW-1:0] exp_ard [2];
  logic [DW-1:0] exp_brd [2];
  int            edges;
  int            n_checks;
  int            n_fail;

  logic          obs_ga [2];
  logic          obs_gb [2];
  logic          obs_we [2];
  logic          obs_done [2];
  logic [AW-1:0] obs_addr [2];

  task automatic model_reset();
    edges = 0;
    for (int i = 0; i < 2; i++) begin
      pref_b[i] = 1'b0;
      last_addr[i] = '0;
      exp_arv[i] = 1'b0;
      exp_brv[i] = 1'b0;
      exp_ard[i] = '0;
      exp_brd[i] = '0;
    end
  endtask

  // One clock of stimulus; starts and ends 1ns after a rising edge.
  task automatic run_cycle(input logic av, input logic awe, input logic [AW-1:0] aad,
                           input logic [DW-1:0] awd, input logic bv, input logic bwe,
                           input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
    bit ga [2];
    bit gb [2];
    bit clr;
    logic ewe;
    logic [AW-1:0] ead;
    logic [DW-1:0] ewd;
    a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
    b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
    #3;
    clr = (edges < CLR_CYC);
    for (int i = 0; i < 2; i++) begin
      ga[i] = 1'b0;
      gb[i] = 1'b0;
      if (!clr) begin
        if (av && bv) begin
          if (i == 1 || !pref_b[i]) ga[i] = 1'b1;
          else gb[i] = 1'b1;
        end else begin
          ga[i] = av;
          gb[i] = bv;
        end
      end
      ewe = 1'b0; ead = last_addr[i]; ewd = '0;
      if (ga[i]) begin
        ewe = awe; ead = aad; ewd = awd;
      end else if (gb[i]) begin
        ewe = bwe; ead = bad; ewd = bwd;
      end else if (clr && CLR_CYC > 1) begin
        ewe = 1'b1; ead = AW'(edges); ewd = '0;
      end
      n_checks++;
      if (a_ready_w[i] !== ga[i] || b_ready_w[i] !== gb[i]) begin
        n_fail++;
        $display("FAIL grant inst%0d t=%0t: a_ready=%b b_ready=%b, required %b %b",
                 i, $time, a_ready_w[i], b_ready_w[i], ga[i], gb[i]);
      end
      n_checks++;
      if (mem_we_w[i] !== ewe || mem_addr_w[i] !== ead) begin
        n_fail++;
        $display("FAIL bus inst%0d t=%0t: we=%b addr=%h, required we=%b addr=%h",
                 i, $time, mem_we_w[i], mem_addr_w[i], ewe, ead);
      end
      if (ewe) begin
        n_checks++;
        if (mem_wdata_w[i] !== ewd) begin
          n_fail++;
          $display("FAIL wdata inst%0d t=%0t: got %h, required %h", i, $time, mem_wdata_w[i], ewd);
        end
      end
      n_checks++;
      if (clear_done_w[i] !== !clr) begin
        n_fail++;
        $display("FAIL clear_done inst%0d t=%0t: got %b, required %b",
                 i, $time, clear_done_w[i], !clr);
      end
      obs_ga[i] = a_ready_w[i];
      obs_gb[i] = b_ready_w[i];
      obs_we[i] = mem_we_w[i];
      obs_addr[i] = mem_addr_w[i];
      obs_done[i] = clear_done_w[i];
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_arv[i] = ga[i];
      exp_brv[i] = gb[i];
      if (ga[i]) begin
        exp_ard[i] = ref_mem[i][aad];
        if (awe) ref_mem[i][aad] = awd;
        last_addr[i] = aad;
        pref_b[i] = 1'b1;
      end else if (gb[i]) begin
        exp_brd[i] = ref_mem[i][bad];
        if (bwe) ref_mem[i][bad] = bwd;
        last_addr[i] = bad;
        pref_b[i] = 1'b0;
      end else if (clr && CLR_CYC > 1) begin
        ref_mem[i][edges] = '0;
        last_addr[i] = AW'(edges);
      end
    end
    if (edges < CLR_CYC) edges++;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (a_rsp_valid_w[i] !== exp_arv[i] || a_rsp_data_w[i] !== exp_ard[i]) begin
        n_fail++;
        $display("FAIL a_rsp inst%0d t=%0t: valid=%b data=%h, required %b %h",
                 i, $time, a_rsp_valid_w[i], a_rsp_data_w[i], exp_arv[i], exp_ard[i]);
      end
      n_checks++;
      if (b_rsp_valid_w[i] !== exp_brv[i] || b_rsp_data_w[i] !== exp_brd[i]) begin
        n_fail++;
        $display("FAIL b_rsp inst%0d t=%0t: valid=%b data=%h, required %b %h",
                 i, $time, b_rsp_valid_w[i], b_rsp_data_w[i], exp_brv[i], exp_brd[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; a_we = 1'b1; b_we = 1'b1;
    a_addr = 6'h2A; b_addr = 6'h15; a_wdata = 4'h5; b_wdata = 4'h9;
    @(posedge clk); #1;
    for (int k = 0; k < DEPTH; k++) begin
      load_en = 1'b1;
      load_addr = AW'(k);
      load_data = DW'($urandom_range(0, 15));
      ref_mem[0][k] = load_data;
      ref_mem[1][k] = load_data;
      @(posedge clk); #1;
    end
    load_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({a_ready_w[i], b_ready_w[i], a_rsp_valid_w[i], b_rsp_valid_w[i], mem_we_w[i],
           clear_done_w[i]} !== 6'b0 || mem_addr_w[i] !== '0 || mem_wdata_w[i] !== '0 ||
          a_rsp_data_w[i] !== '0 || b_rsp_data_w[i] !== '0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: rdy=%b%b rsp=%b%b we=%b done=%b addr=%h wd=%h, required 0",
                 i, a_ready_w[i], b_ready_w[i], a_rsp_valid_w[i], b_rsp_valid_w[i],
                 mem_we_w[i], clear_done_w[i], mem_addr_w[i], mem_wdata_w[i]);
      end
    end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_clear();
    logic [DW-1:0] exp17;
    for (int k = 0; k < CLR_CYC; k++) begin
      run_cycle(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
                1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
    end
    exp17 = ref_mem[0][17];
`ifdef MEM_CLEAR_EN
    exp17 = '0;
`endif
    run_cycle(1'b1, 1'b0, 6'd17, 4'h0, 1'b0, 1'b0, 6'd0, 4'h0);
    n_checks++;
    if (obs_done[0] !== 1'b1 || obs_ga[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_done_rise: done=%b a_ready=%b, required 1 1", obs_done[0], obs_ga[0]);
    end
    n_checks++;
    if (a_rsp_valid_w[0] !== 1'b1 || a_rsp_data_w[0] !== exp17) begin
      n_fail++;
      $display("FAIL read17: valid=%b data=%h, required 1 %h", a_rsp_valid_w[0], a_rsp_data_w[0], exp17);
    end
  endtask

  task automatic test_single_write();
    run_cycle(1'b1, 1'b1, 6'h05, 4'hA, 1'b0, 1'b0, 6'h00, 4'h0);
    n_checks++;
    if (obs_ga[0] !== 1'b1 || obs_we[0] !== 1'b1 || obs_addr[0] !== 6'h05) begin
      n_fail++;
      $display("FAIL single_write: a_ready=%b we=%b addr=%h, required 1 1 05",
               obs_ga[0], obs_we[0], obs_addr[0]);
    end
    n_checks++;
    if (a_rsp_valid_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL write_rsp: a_rsp_valid=%b, required 1", a_rsp_valid_w[0]);
    end
    run_cycle(1'b0, 1'b0, 6'h00, 4'h0, 1'b0, 1'b0, 6'h00, 4'h0);
    n_checks++;
    if (a_rsp_valid_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_one_pulse: a_rsp_valid=%b, required 0", a_rsp_valid_w[0]);
    end
    run_cycle(1'b1, 1'b0, 6'h05, 4'h0, 1'b0, 1'b0, 6'h00, 4'h0);
    n_checks++;
    if (a_rsp_data_w[0] !== 4'hA || a_rsp_data_w[1] !== 4'hA) begin
      n_fail++;
      $display("FAIL readback_05: got %h/%h, required a/a", a_rsp_data_w[0], a_rsp_data_w[1]);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq_a, seq_b;
    int ca, cb, lone;
    ca = 0; cb = 0; lone = 0;
    run_cycle(1'b0, 1'b0, 6'h00, 4'h0, 1'b1, 1'b0, 6'h01, 4'h0);
    for (int k = 0; k < 4; k++) begin
      run_cycle(1'b1, 1'b0, AW'($urandom), 4'h0, 1'b1, 1'b0, AW'($urandom), 4'h0);
      seq_a[k] = obs_ga[0];
      seq_b[k] = obs_gb[0];
      ca += int'(a_rsp_valid_w[0]);
      cb += int'(b_rsp_valid_w[0]);
    end
    n_checks++;
    if (seq_a !== 4'b0101 || seq_b !== 4'b1010 || ca != 2 || cb != 2) begin
      n_fail++;
      $display("FAIL round_robin: a=%b b=%b rspA=%0d rspB=%0d, required 0101 1010 2 2",
               seq_a, seq_b, ca, cb);
    end
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b1, 1'b0, AW'($urandom), 4'h0, 1'b0, 1'b0, 6'h00, 4'h0);
      lone += int'(obs_ga[0]);
    end
    n_checks++;
    if (lone != 3) begin
      n_fail++;
      $display("FAIL lone_back_to_back: grants=%0d, required 3", lone);
    end
  endtask

  task automatic test_fixed_priority();
    int ga, gb;
    ga = 0; gb = 0;
    for (int k = 0; k < 4; k++) begin
      run_cycle(1'b1, 1'b0, AW'($urandom), 4'h0, 1'b1, 1'b0, AW'($urandom), 4'h0);
      ga += int'(obs_ga[1]);
      gb += int'(obs_gb[1]);
    end
    n_checks++;
    if (ga != 4 || gb != 0) begin
      n_fail++;
      $display("FAIL fixed_priority: A grants=%0d B grants=%0d, required 4 0", ga, gb);
    end
    run_cycle(1'b0, 1'b0, 6'h00, 4'h0, 1'b1, 1'b0, 6'h09, 4'h0);
    n_checks++;
    if (obs_gb[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed_b_after_a_drops: b_ready=%b, required 1", obs_gb[1]);
    end
  endtask

  task automatic test_raw_wrap();
    logic [AW-1:0] wa;
    run_cycle(1'b0, 1'b0, 6'h00, 4'h0, 1'b1, 1'b1, 6'h3F, 4'h7);
    run_cycle(1'b1, 1'b0, 6'h3F, 4'h0, 1'b0, 1'b0, 6'h00, 4'h0);
    n_checks++;
    if (a_rsp_valid_w[0] !== 1'b1 || a_rsp_data_w[0] !== 4'h7 || a_rsp_data_w[1] !== 4'h7) begin
      n_fail++;
      $display("FAIL read_after_write: valid=%b data=%h/%h, required 1 7/7",
               a_rsp_valid_w[0], a_rsp_data_w[0], a_rsp_data_w[1]);
    end
    wa = 6'h3F;
    wa = wa + AW'(1);
    run_cycle(1'b1, 1'b1, wa, 4'h3, 1'b0, 1'b0, 6'h00, 4'h0);
    n_checks++;
    if (obs_addr[0] !== 6'h00) begin
      n_fail++;
      $display("FAIL wrap_addr: mem_addr=%h, required 00", obs_addr[0]);
    end
    run_cycle(1'b0, 1'b0, 6'h00, 4'h0, 1'b1, 1'b0, 6'h00, 4'h0);
    n_checks++;
    if (b_rsp_data_w[0] !== 4'h3) begin
      n_fail++;
      $display("FAIL wrap_readback: b_rsp_data=%h, required 3", b_rsp_data_w[0]);
    end
  endtask

  task automatic test_random(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      run_cycle(1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom),
                1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
    end
  endtask

  task automatic test_reset_mid_op();
    bit found;
    found = 1'b0;
    run_cycle(1'b1, 1'b0, AW'($urandom), 4'h0, 1'b0, 1'b0, 6'h00, 4'h0);
    n_checks++;
    if (a_rsp_valid_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_rsp: a_rsp_valid=%b, required 1", a_rsp_valid_w[0]);
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (a_rsp_valid_w[i] !== 1'b0 || a_rsp_data_w[i] !== '0 || clear_done_w[i] !== 1'b0 ||
          mem_we_w[i] !== 1'b0 || mem_addr_w[i] !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_op inst%0d: rsp=%b data=%h done=%b we=%b addr=%h, required 0",
                 i, a_rsp_valid_w[i], a_rsp_data_w[i], clear_done_w[i], mem_we_w[i], mem_addr_w[i]);
      end
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < CLR_CYC + 2 && !found; k++) begin
      run_cycle(1'b1, 1'b0, AW'($urandom), 4'h0, 1'b1, 1'b0, AW'($urandom), 4'h0);
      if (k == 0) begin
        n_checks++;
        if (obs_addr[0] !== 6'h00) begin
          n_fail++;
          $display("FAIL clear_restart: mem_addr=%h, required 00", obs_addr[0]);
        end
      end
      if (obs_done[0] === 1'b1) begin
        found = 1'b1;
        n_checks++;
        if (obs_ga[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_after_reset: a_ready=%b, required 1", obs_ga[0]);
        end
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL serve_after_reset: clear_done=0, required 1 within %0d cycles", CLR_CYC + 2);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    rst = 1'b1;
    test_reset();
    test_clear();
    test_single_write();
    test_round_robin();
    test_fixed_priority();
    test_raw_wrap();
    test_random(300);
    test_reset_mid_op();
    test_random(100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
